// File: rtl/zacore_fetch_queue.sv
// Prefetch unit: fetches sequentially from a req/ack instruction port into a DEPTH-entry queue for decode.
// Latency: ack-to-o_valid 1 cycle; backpressure via i_stall, fetch pauses while the queue would be full.
module zacore_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    output logic                       o_fetch_req,
    input  logic                       i_fetch_ack,
    output logic [XLEN-1:0]            o_fetch_addr,
    input  logic [31:0]                i_inst_read,
    output logic                       o_valid,
    output logic [31:0]                o_inst,
    output logic [XLEN-1:0]            o_pc,
    input  logic                       i_stall,
    input  logic                       i_invalidate,
    input  logic [XLEN-1:0]            i_redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic            push, pop, space;
    logic [XLEN-1:0] redirect, pc_inc;
    logic            redirect_lsb_unused;

    assign redirect_lsb_unused = ^i_redirect_pc[1:0];
    assign redirect = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign pc_inc   = fetch_pc_q + XLEN'(4);

    // Invalidate wins over both queue ports: ack data and any pop are dropped.
    assign push = (state_q == FETCH) && i_fetch_ack && !i_invalidate;
    assign pop  = (count_q != '0) && !i_stall && !i_invalidate;

    always_comb begin
        count_d = count_q;
        if (i_invalidate)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    assign space = (count_d < DEPTH_C);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            IDLE: begin
                if (i_invalidate) begin
                    fetch_pc_d = redirect;
                    addr_d     = redirect;
                    state_d    = FETCH;
                end else if (space) begin
                    addr_d  = fetch_pc_q;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (i_invalidate) begin
                    fetch_pc_d = redirect;
                    if (i_fetch_ack) addr_d = redirect;
                    // Without an ack the request must stay up; its result gets squashed.
                    state_d = i_fetch_ack ? FETCH : DISCARD;
                end else if (i_fetch_ack) begin
                    fetch_pc_d = pc_inc;
                    addr_d     = pc_inc;
                    state_d    = space ? FETCH : IDLE;
                end
            end
            DISCARD: begin
                if (i_invalidate) fetch_pc_d = redirect;
                if (i_fetch_ack) begin
                    addr_d  = i_invalidate ? redirect : fetch_pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            if (i_invalidate) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= i_inst_read;
            pc_mem[wr_ptr]   <= addr_q;
        end
    end

    assign o_fetch_req  = (state_q != IDLE);
    assign o_fetch_addr = addr_q;
    assign o_count      = count_q;
    assign o_valid      = (count_q != '0);
    assign o_inst       = o_valid ? inst_mem[rd_ptr] : '0;
    assign o_pc         = o_valid ? pc_mem[rd_ptr]   : '0;

endmodule

// File: tb/tb_zacore_fetch_queue.sv
// Directed bench for zacore_fetch_queue: sequential fetch, full-queue stall, redirect squash, wrap and async reset.
module tb_zacore_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n, fetch_req, fetch_ack, valid, stall, invalidate;
    logic [31:0] fetch_addr, inst_read, inst, pc, redirect_pc;
    logic [2:0]  count;

    logic        rst6_n, req6, ack6, valid6;
    logic [31:0] addr6, inst6_read, inst6, pc6;
    logic [2:0]  count6;

    int checks = 0;
    int errors = 0;
    int acks;

    always #5 clk = ~clk;

    zacore_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_fetch_req(fetch_req), .i_fetch_ack(fetch_ack),
        .o_fetch_addr(fetch_addr), .i_inst_read(inst_read), .o_valid(valid), .o_inst(inst),
        .o_pc(pc), .i_stall(stall), .i_invalidate(invalidate), .i_redirect_pc(redirect_pc),
        .o_count(count)
    );

    zacore_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut6 (
        .i_clk(clk), .i_rst_n(rst6_n), .o_fetch_req(req6), .i_fetch_ack(ack6),
        .o_fetch_addr(addr6), .i_inst_read(inst6_read), .o_valid(valid6), .o_inst(inst6),
        .o_pc(pc6), .i_stall(stall), .i_invalidate(invalidate), .i_redirect_pc(redirect_pc),
        .o_count(count6)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory answers immediately when enabled and a request is up.
    task automatic drive(input logic ack_en);
        fetch_ack = ack_en & fetch_req;
        inst_read = mem_word(fetch_addr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fetch_ack = 1'b0; invalidate = 1'b0; stall = 1'b0; redirect_pc = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; fetch_ack = 1'b0; inst_read = '0; stall = 1'b0;
        invalidate = 1'b0; redirect_pc = '0;
        rst6_n = 1'b0; ack6 = 1'b0; inst6_read = '0;
        #2;
        chk("rst_req",   32'(fetch_req), 32'd0);
        chk("rst_addr",  fetch_addr,     32'h0);
        chk("rst_valid", 32'(valid),     32'd0);
        chk("rst_inst",  inst,           32'h0);
        chk("rst_pc",    pc,             32'h0);
        chk("rst_count", 32'(count),     32'd0);
        tick();

        // 1: sequential fetch, ack every cycle, no stall
        do_reset();
        drive(1'b1); tick();
        chk("t1_req", 32'(fetch_req), 32'd1);
        chk("t1_addr0", fetch_addr, 32'h0);
        chk("t1_valid_pre", 32'(valid), 32'd0);
        drive(1'b1); tick();
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_pc0", pc, 32'h0);
        chk("t1_inst0", inst, mem_word(32'h0));
        chk("t1_addr1", fetch_addr, 32'h4);
        for (int j = 1; j <= 4; j++) begin
            drive(1'b1); tick();
            chk("t1_pc", pc, 32'(4 * j));
            chk("t1_inst", inst, mem_word(32'(4 * j)));
            chk("t1_addr", fetch_addr, 32'(4 * j + 4));
            chk("t1_count", 32'(count), 32'd1);
        end

        // 2: stalled decode fills the queue, then fetch resumes at 0x10
        do_reset();
        stall = 1'b1;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1);
            if (fetch_ack) acks++;
            tick();
        end
        chk("t2_acks", 32'(acks), 32'd4);
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_req_off", 32'(fetch_req), 32'd0);
        chk("t2_head_pc", pc, 32'h0);
        stall = 1'b0;
        drive(1'b1); tick();
        chk("t2_req_on", 32'(fetch_req), 32'd1);
        chk("t2_addr", fetch_addr, 32'h10);
        chk("t2_count_pop", 32'(count), 32'd3);
        chk("t2_head_pc2", pc, 32'h4);

        // 3: invalidate while the request to 0x8 is waiting on a slow ack
        do_reset();
        drive(1'b0); tick();
        drive(1'b1); tick();
        drive(1'b1); tick();
        chk("t3_addr8", fetch_addr, 32'h8);
        drive(1'b0); tick();
        invalidate = 1'b1; redirect_pc = 32'h100;
        drive(1'b0); tick();
        invalidate = 1'b0;
        chk("t3_req_held", 32'(fetch_req), 32'd1);
        chk("t3_addr_held", fetch_addr, 32'h8);
        chk("t3_valid_flush", 32'(valid), 32'd0);
        drive(1'b1); tick();
        chk("t3_addr_redir", fetch_addr, 32'h100);
        chk("t3_dropped", 32'(count), 32'd0);
        drive(1'b1); tick();
        chk("t3_pc_redir", pc, 32'h100);
        chk("t3_inst_redir", inst, mem_word(32'h100));

        // 4: invalidate coinciding with ack and pop, unaligned target
        invalidate = 1'b1; redirect_pc = 32'h203;
        drive(1'b1); tick();
        invalidate = 1'b0;
        chk("t4_valid", 32'(valid), 32'd0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_pc_zero", pc, 32'h0);
        chk("t4_inst_zero", inst, 32'h0);
        chk("t4_addr", fetch_addr, 32'h200);
        drive(1'b1); tick();
        chk("t4_pc", pc, 32'h200);
        chk("t4_inst", inst, mem_word(32'h200));

        // 5: steady push+pop at count=DEPTH-1 across pointer wraps
        do_reset();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1); tick();
        end
        chk("t5_fill", 32'(count), 32'd3);
        stall = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            drive(1'b1); tick();
            chk("t5_count", 32'(count), 32'd3);
            chk("t5_pc", pc, 32'(4 * k));
            chk("t5_inst", inst, mem_word(32'(4 * k)));
        end

        // 6: fetch address wrap and asynchronous reset mid-request
        fetch_ack = 1'b0;
        rst6_n = 1'b1;
        tick();
        chk("t6_req", 32'(req6), 32'd1);
        chk("t6_addr_top", addr6, 32'hFFFF_FFFC);
        ack6 = 1'b1; inst6_read = mem_word(32'hFFFF_FFFC);
        tick();
        ack6 = 1'b0;
        chk("t6_addr_wrap", addr6, 32'h0);
        chk("t6_pc", pc6, 32'hFFFF_FFFC);
        tick();
        chk("t6_req_pending", 32'(req6), 32'd1);
        #2 rst6_n = 1'b0;
        #1;
        chk("t6_async_req", 32'(req6), 32'd0);
        chk("t6_async_addr", addr6, 32'hFFFF_FFFC);
        chk("t6_async_count", 32'(count6), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
